// File: rtl/cam_pkg.sv
// cam_pkg: shared state encoding and FIFO entry layout for the camera scan controller
package cam_pkg;
  localparam int DEF_DATA_WIDTH = 8;
  typedef enum logic [2:0] {IDLE, ACTIVE, HBLANK, VBLANK, DRAIN} cam_state_t;
  typedef struct packed {
    logic [DEF_DATA_WIDTH-1:0] data;
    logic                      sof;
    logic                      eol;
  } cam_pix_t;
endpackage

// File: rtl/cam_scan_ctrl_if.sv
// cam_scan_ctrl_if: pixel stream with start-of-frame and end-of-line markers
interface cam_scan_ctrl_if #(parameter int DATA_WIDTH = 8);
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_valid;
  logic                  m_ready;
  logic                  m_sof;
  logic                  m_eol;
  modport master (output m_data, m_valid, m_sof, m_eol, input m_ready);
  modport slave (input m_data, m_valid, m_sof, m_eol, output m_ready);
endinterface

// File: rtl/cam_skid_fifo.sv
// cam_skid_fifo: 2-entry FIFO whose head entry is a register driving the output directly
module cam_skid_fifo
  import cam_pkg::*;
#(
  parameter type T = cam_pix_t
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       push,
  input  logic       pop,
  input  T           din,
  output T           dout,
  output logic [1:0] count,
  output logic       full,
  output logic       empty
);
  T tail;
  assign full = count == 2'd2;
  assign empty = count == 2'd0;
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      dout <= '0;
      tail <= '0;
      count <= '0;
    end else begin
      count <= count + {1'b0, push} - {1'b0, pop};
      if (pop && full) dout <= tail;
      else if (push && (empty || (pop && count == 2'd1))) dout <= din;
      if (push && (pop ? full : count == 2'd1)) tail <= din;
    end
endmodule

// File: rtl/cam_scan_ctrl.sv
// cam_scan_ctrl: raster scan sequencer for the cam source with a credit-limited valid/ready pixel stream
module cam_scan_ctrl
  import cam_pkg::*;
#(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int DATA_WIDTH = 8,
  parameter int H_BLANK    = 16,
  parameter int V_BLANK    = 8
) (
  input  logic                          clk,
  input  logic                          n_rst,
  input  logic                          start,
  input  logic                          continuous,
  input  logic                          stop,
  output logic [$clog2(IMG_WIDTH)-1:0]  hcount,
  output logic [$clog2(IMG_HEIGHT)-1:0] vcount,
  input  logic [DATA_WIDTH-1:0]         pix_in,
  output logic                          busy,
  output logic                          frame_done,
  output logic [15:0]                   frame_cnt,
  cam_scan_ctrl_if.master               m
);
  localparam int HW = $clog2(IMG_WIDTH);
  localparam int VW = $clog2(IMG_HEIGHT);
  localparam int BMAX = H_BLANK > V_BLANK ? H_BLANK : V_BLANK;
  localparam int BW = BMAX > 0 ? $clog2(BMAX + 1) : 1;
  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic                  sof;
    logic                  eol;
  } pix_t;
  cam_state_t    state;
  pix_t          head;
  logic [1:0]    occ;
  logic [BW-1:0] bcnt;
  logic [VW-1:0] orow;
  logic          cont, stop_pending, inflight, sof1, eol1;
  logic          full, empty, pop, credit, issue, last_col, last_row, fin;
  assign pop = m.m_valid && m.m_ready;
  assign credit = full ? pop : ({1'b0, occ} + {2'b0, inflight} < {2'b0, pop} + 3'd2);
  assign issue = state == ACTIVE && credit;
  assign last_col = hcount == HW'(IMG_WIDTH - 1);
  assign last_row = vcount == VW'(IMG_HEIGHT - 1);
  assign fin = pop && head.eol && !head.sof && orow == VW'(IMG_HEIGHT - 1);
  assign busy = state != IDLE;
  assign m.m_valid = !empty;
  assign m.m_data = head.data;
  assign m.m_sof = head.sof;
  assign m.m_eol = head.eol;
  cam_skid_fifo #(.T(pix_t)) u_fifo (
    .clk   (clk),
    .n_rst (n_rst),
    .push  (inflight),
    .pop   (pop),
    .din   (pix_t'{pix_in, sof1, eol1}),
    .dout  (head),
    .count (occ),
    .full  (full),
    .empty (empty)
  );
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      state <= IDLE;
      hcount <= '0;
      vcount <= '0;
      bcnt <= '0;
      orow <= '0;
      cont <= 1'b0;
      stop_pending <= 1'b0;
      inflight <= 1'b0;
      sof1 <= 1'b0;
      eol1 <= 1'b0;
      frame_done <= 1'b0;
      frame_cnt <= '0;
    end else begin
      inflight <= issue;
      if (issue) begin
        sof1 <= hcount == '0 && vcount == '0;
        eol1 <= last_col;
      end
      frame_done <= fin;
      if (fin) frame_cnt <= frame_cnt + 16'd1;
      if (pop && head.eol) orow <= orow == VW'(IMG_HEIGHT - 1) ? '0 : orow + 1'b1;
      if (stop && state != IDLE) stop_pending <= 1'b1;
      case (state)
        IDLE: if (start) begin
          state <= ACTIVE;
          cont <= continuous;
          stop_pending <= stop;
        end
        ACTIVE: if (issue) begin
          hcount <= last_col ? '0 : hcount + 1'b1;
          if (last_col) begin
            vcount <= last_row ? '0 : vcount + 1'b1;
            if (!last_row) state <= H_BLANK > 0 ? HBLANK : ACTIVE;
            else if (cont && !stop_pending && !stop) state <= V_BLANK > 0 ? VBLANK : ACTIVE;
            else state <= DRAIN;
          end
        end
        HBLANK: begin
          bcnt <= bcnt == BW'(H_BLANK - 1) ? '0 : bcnt + 1'b1;
          if (bcnt == BW'(H_BLANK - 1)) state <= ACTIVE;
        end
        VBLANK: begin
          bcnt <= bcnt == BW'(V_BLANK - 1) ? '0 : bcnt + 1'b1;
          if (bcnt == BW'(V_BLANK - 1)) state <= ACTIVE;
        end
        DRAIN: if (!inflight && empty) begin
          state <= IDLE;
          stop_pending <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_cam_scan_ctrl.sv
// tb_cam_scan_ctrl: directed scoreboard bench for cam_scan_ctrl with normal and zero-blanking instances
module tb_cam_scan_ctrl;
  localparam int W = 4;
  localparam int H = 3;
  typedef logic [9:0] ent_t;
  logic clk = 1'b0;
  logic n_rst = 1'b1;
  always #5 clk = ~clk;
  logic start = 1'b0, continuous = 1'b0, stop = 1'b0, busy, frame_done;
  logic [1:0] hcount, vcount;
  logic [7:0] pix_in = '0;
  logic [15:0] frame_cnt;
  logic zstart = 1'b0, zcont = 1'b1, zstop = 1'b0, zbusy, zfd;
  logic [1:0] zh, zv;
  logic [7:0] zpix = '0;
  logic [15:0] zfc;
  cam_scan_ctrl_if #(.DATA_WIDTH(8)) s ();
  cam_scan_ctrl_if #(.DATA_WIDTH(8)) sz ();
  cam_scan_ctrl #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .DATA_WIDTH(8), .H_BLANK(2), .V_BLANK(3)) dut (
    .clk(clk), .n_rst(n_rst), .start(start), .continuous(continuous), .stop(stop),
    .hcount(hcount), .vcount(vcount), .pix_in(pix_in), .busy(busy),
    .frame_done(frame_done), .frame_cnt(frame_cnt), .m(s)
  );
  cam_scan_ctrl #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .DATA_WIDTH(8), .H_BLANK(0), .V_BLANK(0)) dut_z (
    .clk(clk), .n_rst(n_rst), .start(zstart), .continuous(zcont), .stop(zstop),
    .hcount(zh), .vcount(zv), .pix_in(zpix), .busy(zbusy),
    .frame_done(zfd), .frame_cnt(zfc), .m(sz)
  );
  always @(posedge clk) pix_in <= {2'b00, vcount, 2'b00, hcount};
  always @(posedge clk) zpix <= {2'b00, zv, 2'b00, zh};
  int checks = 0, errors = 0, cyc = 0;
  int pops = 0, fd_seen = 0, fc_model = 0, last_pop_edge = 0;
  int sof_edges[$], zsof[$];
  ent_t q[$], qz[$];
  ent_t held;
  logic stalled = 1'b0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic push_frames(input int n, input bit z);
    for (int f = 0; f < n; f++)
      for (int v = 0; v < H; v++)
        for (int h = 0; h < W; h++)
          if (z) qz.push_back({8'(v * 16 + h), v == 0 && h == 0, h == W - 1});
          else q.push_back({8'(v * 16 + h), v == 0 && h == 0, h == W - 1});
  endtask
  task automatic chk_reset(input string p);
    chk({p, "_hcount"}, hcount, 0);
    chk({p, "_vcount"}, vcount, 0);
    chk({p, "_m_data"}, s.m_data, 0);
    chk({p, "_m_valid"}, s.m_valid, 0);
    chk({p, "_m_sof"}, s.m_sof, 0);
    chk({p, "_m_eol"}, s.m_eol, 0);
    chk({p, "_busy"}, busy, 0);
    chk({p, "_frame_done"}, frame_done, 0);
    chk({p, "_frame_cnt"}, frame_cnt, 0);
  endtask
  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
    continuous = 1'b0;
    stop = 1'b0;
  endtask
  task automatic do_reset();
    n_rst = 1'b0;
    tick(1);
    n_rst = 1'b1;
    tick(1);
  endtask
  task automatic wait_idle(input int budget, input bit rnd);
    for (int i = 0; i < budget && busy; i++) begin
      if (rnd) s.m_ready = $urandom_range(0, 99) < 30;
      tick(1);
    end
    s.m_ready = 1'b1;
    chk("idle_reached", busy, 0);
    chk("busy_fall_after_last_pop", cyc, last_pop_edge + 1);
  endtask
  always @(negedge clk) begin
    if (!n_rst) begin
      fc_model <= 0;
      stalled <= 1'b0;
    end else begin
      if (stalled && s.m_valid) chk("stall_hold", {s.m_data, s.m_sof, s.m_eol}, held);
      stalled <= s.m_valid && !s.m_ready;
      held <= {s.m_data, s.m_sof, s.m_eol};
      if (s.m_valid && s.m_ready) begin
        chk("pixel_expected", 32'(q.size() != 0), 1);
        if (q.size() != 0) chk("pixel", {s.m_data, s.m_sof, s.m_eol}, q.pop_front());
        pops <= pops + 1;
        last_pop_edge <= cyc + 1;
        if (s.m_sof) sof_edges.push_back(cyc + 1);
      end
      if (frame_done) begin
        chk("frame_cnt_step", frame_cnt, fc_model + 1);
        fc_model <= fc_model + 1;
        fd_seen <= fd_seen + 1;
      end
    end
  end
  always @(negedge clk)
    if (n_rst && sz.m_valid && sz.m_ready) begin
      chk("z_pixel_expected", 32'(qz.size() != 0), 1);
      if (qz.size() != 0) chk("z_pixel", {sz.m_data, sz.m_sof, sz.m_eol}, qz.pop_front());
      if (sz.m_sof) zsof.push_back(cyc + 1);
    end
  initial begin
    int base, fd0, gaps;
    s.m_ready = 1'b1;
    sz.m_ready = 1'b1;
    #1 n_rst = 1'b0;
    #1 chk_reset("rst");
    tick(2);
    n_rst = 1'b1;
    tick(1);
    push_frames(1, 0);
    fd0 = fd_seen;
    pulse_start();
    chk("lat_busy", busy, 1);
    chk("lat_addr", {vcount, hcount}, 0);
    chk("lat_valid_k", s.m_valid, 0);
    tick(1);
    chk("lat_valid_k1", s.m_valid, 0);
    tick(1);
    chk("lat_valid_k2", s.m_valid, 1);
    chk("lat_sof_k2", s.m_sof, 1);
    wait_idle(200, 0);
    chk("ss_frame_cnt", frame_cnt, 1);
    chk("ss_frame_done_once", fd_seen - fd0, 1);
    chk("ss_queue_drained", q.size(), 0);
    do_reset();
    push_frames(3, 0);
    base = sof_edges.size();
    fd0 = fd_seen;
    continuous = 1'b1;
    pulse_start();
    for (int i = 0; i < 200 && fd_seen < fd0 + 2; i++) tick(1);
    chk("cont_two_frames", fd_seen - fd0, 2);
    tick(5);
    chk("cont_busy_mid3", busy, 1);
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    wait_idle(200, 0);
    chk("cont_frame_cnt", frame_cnt, 3);
    chk("cont_queue_drained", q.size(), 0);
    chk("cont_sof_count", sof_edges.size() - base, 3);
    chk("cont_period_1", sof_edges[base + 1] - sof_edges[base], 19);
    chk("cont_period_2", sof_edges[base + 2] - sof_edges[base + 1], 19);
    do_reset();
    push_frames(1, 0);
    pulse_start();
    wait_idle(1000, 1);
    chk("bp_frame_cnt", frame_cnt, 1);
    chk("bp_queue_drained", q.size(), 0);
    push_frames(1, 0);
    continuous = 1'b1;
    stop = 1'b1;
    pulse_start();
    tick(6);
    pulse_start();
    wait_idle(200, 0);
    tick(5);
    chk("ss2_still_idle", busy, 0);
    chk("ss2_frame_cnt", frame_cnt, 2);
    chk("ss2_queue_drained", q.size(), 0);
    do_reset();
    base = pops;
    push_frames(1, 0);
    pulse_start();
    for (int i = 0; i < 200 && pops < base + 11; i++) tick(1);
    chk("mr_pops_reached", pops - base, 11);
    n_rst = 1'b0;
    #1 chk_reset("mr");
    q.delete();
    tick(1);
    n_rst = 1'b1;
    tick(1);
    push_frames(1, 0);
    pulse_start();
    chk("mr_restart_addr", {vcount, hcount}, 0);
    chk("mr_restart_cnt", frame_cnt, 0);
    chk("mr_restart_busy", busy, 1);
    wait_idle(200, 0);
    chk("mr_frame_cnt", frame_cnt, 1);
    chk("mr_queue_drained", q.size(), 0);
    push_frames(3, 1);
    zstart = 1'b1;
    tick(1);
    zstart = 1'b0;
    for (int i = 0; i < 10 && !sz.m_valid; i++) tick(1);
    chk("z_first_valid", sz.m_valid, 1);
    gaps = 0;
    for (int i = 0; i < 36; i++) begin
      gaps += int'(!sz.m_valid);
      zstop = i == 28;
      tick(1);
    end
    zstop = 1'b0;
    chk("z_no_gaps", gaps, 0);
    for (int i = 0; i < 100 && zbusy; i++) tick(1);
    chk("z_idle", zbusy, 0);
    chk("z_frame_cnt", zfc, 3);
    chk("z_queue_drained", qz.size(), 0);
    chk("z_sof_count", zsof.size(), 3);
    chk("z_period_1", zsof[1] - zsof[0], 12);
    chk("z_period_2", zsof[2] - zsof[1], 12);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/cam_scan_ctrl.md
# cam_scan_ctrl

Scan sequencer and stream adapter for the camera pixel source `cam`.
- Drives the source's `hcount`/`vcount` read address in raster order, with programmable horizontal and vertical blanking.
- Captures the returned pixel and presents it downstream as a valid/ready stream with start-of-frame and end-of-line markers.
- Supports single-shot and continuous capture, and absorbs downstream backpressure without dropping or duplicating pixels.

## Interface
- `IMG_WIDTH`, 640, pixels per line
- `IMG_HEIGHT`, 480, lines per frame
- `DATA_WIDTH`, 8, pixel width
- `H_BLANK`, 16, idle cycles after each line except the last (0 allowed)
- `V_BLANK`, 8, idle cycles after the last line of a frame, continuous mode only (0 allowed)
- `clk`  in  1  single clock for the whole block
- `n_rst`  in  1  asynchronous, active-low reset
- `start`  in  1  begin capture; sampled only in IDLE
- `continuous`  in  1  sampled with `start`: 1 repeats frames, 0 captures one frame
- `stop`  in  1  request halt at the end of the current frame; ignored in IDLE
- `hcount`  out  $clog2(IMG_WIDTH)  column address to `cam`
- `vcount`  out  $clog2(IMG_HEIGHT)  row address to `cam`
- `pix_in`  in  DATA_WIDTH  `cam` dout; valid exactly 1 cycle after the address is presented
- `m_data`  out  DATA_WIDTH  pixel
- `m_valid`  out  1  stream valid
- `m_ready`  in  1  stream ready
- `m_sof`  out  1  marks pixel (0,0)
- `m_eol`  out  1  marks pixel hcount = IMG_WIDTH-1
- `busy`  out  1  state is not IDLE
- `frame_done`  out  1  one-cycle pulse when the last pixel of a frame is accepted
- `frame_cnt`  out  16  completed frames; wraps modulo 2^16

## Operation
- **States and transitions**
  - IDLE: `start` → ACTIVE at (0,0); latch `continuous`.
  - ACTIVE: one address is issued per cycle when credit allows.
    - After column W-1 of a non-last line → HBLANK, or directly to the next line's ACTIVE if H_BLANK=0.
    - After the last pixel of the frame: continuous and no stop pending → VBLANK, or ACTIVE (0,0) if V_BLANK=0; otherwise → DRAIN.
  - HBLANK: H_BLANK cycles, no issue → ACTIVE, next row, column 0.
  - VBLANK: V_BLANK cycles → ACTIVE (0,0).
  - DRAIN: no issue; wait until in-flight = 0 and FIFO empty → IDLE.
- **Addressing**
  - `hcount`/`vcount` hold the current address and advance only on an issue.
  - Both are 0 in IDLE.
- **Credit rule**
  - Issue is allowed iff FIFO occupancy + in-flight − (pop this cycle) < 2.
  - The FIFO has 2 entries; in-flight is at most 1.
  - Pixels therefore never overflow, and throughput is 1 pixel/clk when `m_ready`=1.
- **Tags**
  - Each issued address carries sof/eol tags through the 1-cycle pipe.
  - The tags are written into the FIFO alongside the pixel.
- **Stop handling**
  - `stop` while busy sets stop_pending; it is cleared on entering IDLE.
  - `start` and `stop` in the same IDLE cycle: start wins and stop_pending is set, giving exactly one frame.
  - `start` while busy is ignored.
- **Frame completion**
  - `frame_done`/`frame_cnt` update on the FIFO pop of the pixel tagged sof=0, eol=1, row H-1.
- **Reset**
  - Reset mid-frame discards all state, the FIFO and in-flight data.
  - Outputs return to reset values immediately.

## Timing
- Reset values: `hcount`=0, `vcount`=0, `m_data`=0, `m_valid`=0, `m_sof`=0, `m_eol`=0, `busy`=0, `frame_done`=0, `frame_cnt`=0.
- Start latency:
  - `start` high at edge k → address (0,0) presented in cycle k+1.
  - Pixel written to the FIFO at edge k+2; `m_valid`=1 and `m_sof`=1 from edge k+2.
- FIFO outputs are registered; `m_data` and the tags are stable while `m_valid`=1 and `m_ready`=0.
- A transfer occurs on an edge where `m_valid` and `m_ready` are both high.
- Frame period, continuous, `m_ready`=1: IMG_HEIGHT·IMG_WIDTH + (IMG_HEIGHT−1)·H_BLANK + V_BLANK cycles.
- `busy` falls on the edge after the final pop.

## Structure
- Package `cam_pkg`: state enum `cam_state_t` {IDLE, ACTIVE, HBLANK, VBLANK, DRAIN} and the FIFO entry struct {data, sof, eol}.
- Sub-module `cam_skid_fifo`: 2-entry registered FIFO with push, pop, occupancy count and full/empty flags.
- Blanking counter width: $clog2(max(H_BLANK, V_BLANK)+1).

## Test plan
All scenarios use W=4, H=3, H_BLANK=2, V_BLANK=3, with a `cam` model returning `pix_in` = {vcount, hcount} truncated to 8 bits.
- **Single shot, `m_ready`=1:** `start` at edge 0 → 12 pixels 00..03,10..13,20..23.
  - `m_sof` only on 00; `m_eol` on 03,13,23.
  - `frame_done` once, `frame_cnt`=1.
  - `busy` low after the last pop.
- **Continuous:** 3 frames → each sof 19 cycles apart; `frame_cnt` 1,2,3; `stop` mid frame 3 → IDLE after frame 3 completes.
- **Backpressure:** random `m_ready`, 30% high → the stream equals the single-shot sequence, with no loss or duplicate; `m_data` holds while stalled.
- **Same-cycle `start`+`stop`:** exactly one frame, then IDLE; `start` pulsed while busy has no effect.
- **Reset mid-frame:** after pixel 11, `n_rst` low for 1 cycle → all outputs at reset values; the next `start` begins at (0,0) with `frame_cnt`=0.
- **Zero blanking:** H_BLANK=0, V_BLANK=0 → continuous period = 12 cycles, with no idle gaps in `m_valid`.
